mem_burst_splitter: RTL

MEM_BURST_SPLITTER -- requirements
Module: mem_burst_splitter

---
 rtl/mem_burst_splitter_pkg.sv | 11 +
 rtl/fifo_v3.sv | 42 ++++
 rtl/mem_burst_splitter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/mem_burst_splitter_pkg.sv
// mem_burst_splitter_pkg: shared FSM state, per-beat response tag and helpers for mem_burst_splitter
package mem_burst_splitter_pkg;
  typedef enum logic {IDLE, BURST} state_e;
  typedef struct packed {
    logic we;
    logic last;
  } tag_t;
  function automatic logic is_pow2(input logic [31:0] v);
    return v != 32'd0 && (v & (v - 32'd1)) == 32'd0;
  endfunction
endpackage

// File: rtl/fifo_v3.sv
// fifo_v3: synchronous first-word-registered FIFO used as the read-data buffer
// Ports: clk_i, rst_ni (async active-low); push_i/data_i write side; pop_i/data_o read side;
//        empty_o, usage_o (entries held, 0..DEPTH). Pushes when full and pops when empty are ignored.
module fifo_v3 #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DEPTH = 8,
  localparam int unsigned PtrW = DEPTH > 1 ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  output logic                  empty_o,
  output logic [CntW-1:0]       usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);
  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [CntW-1:0] cnt_q;
  logic push, pop;
  assign push = push_i && cnt_q != CntW'(DEPTH);
  assign pop = pop_i && cnt_q != '0;
  assign empty_o = cnt_q == '0;
  assign usage_o = cnt_q;
  assign data_o = mem_q[rptr_q];
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
      wptr_q <= '0;
      rptr_q <= '0;
    end else begin
      cnt_q <= cnt_q + CntW'(push) - CntW'(pop);
      if (push) wptr_q <= wptr_q == PtrW'(DEPTH - 1) ? '0 : wptr_q + PtrW'(1);
      if (pop) rptr_q <= rptr_q == PtrW'(DEPTH - 1) ? '0 : rptr_q + PtrW'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (push) mem_q[wptr_q] <= data_i;
  end
endmodule

// File: rtl/mem_burst_splitter.sv
// mem_burst_splitter: splits a burst request into single-beat memory requests with credit-limited outstanding traffic
// Ports: clk_i, rst_ni (async active-low);
//   burst_*  : burst command (addr, len = beats-1, we), valid/ready handshake
//   w*       : write beat stream, consumed one per granted write beat
//   r*       : buffered read data stream, rlast_o marks the final beat of a read burst
//   req/gnt/addr/wdata/strb/we, mem_rvalid/mem_rdata : single-request memory port, in-order responses
// Optional: define MEM_BURST_SPLITTER_WRAP_EN to add burst_wrap_i (wrapping bursts).
module mem_burst_splitter
  import mem_burst_splitter_pkg::*;
#(
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned DataWidth = 32,
  parameter int unsigned LenWidth = 8,
  parameter int unsigned MaxTrans = 4
) (
  input  logic                   clk_i,
  input  logic                   rst_ni,
  input  logic                   burst_valid_i,
  output logic                   burst_ready_o,
  input  logic [AddrWidth-1:0]   burst_addr_i,
  input  logic [LenWidth-1:0]    burst_len_i,
  input  logic                   burst_we_i,
`ifdef MEM_BURST_SPLITTER_WRAP_EN
  input  logic                   burst_wrap_i,
`endif
  input  logic                   wvalid_i,
  output logic                   wready_o,
  input  logic [DataWidth-1:0]   wdata_i,
  input  logic [DataWidth/8-1:0] wstrb_i,
  output logic                   rvalid_o,
  input  logic                   rready_i,
  output logic [DataWidth-1:0]   rdata_o,
  output logic                   rlast_o,
  output logic                   req_o,
  input  logic                   gnt_i,
  output logic [AddrWidth-1:0]   addr_o,
  output logic [DataWidth-1:0]   wdata_o,
  output logic [DataWidth/8-1:0] strb_o,
  output logic                   we_o,
  input  logic                   mem_rvalid_i,
  input  logic [DataWidth-1:0]   mem_rdata_i
);
  localparam int unsigned Bytes = DataWidth / 8;
  localparam int unsigned CntW = $clog2(MaxTrans + 1);
  localparam int unsigned PtrW = MaxTrans > 1 ? $clog2(MaxTrans) : 1;
  state_e state_q, state_d;
  logic [AddrWidth-1:0] addr_q, addr_d, addr_inc, addr_nxt;
  logic [LenWidth-1:0] cnt_q, cnt_d;
  logic we_q, we_d;
  logic credit_ok, grant, resp, rd_push, rd_pop, rd_empty;
  logic [CntW-1:0] tag_cnt_q, rd_cnt;
  logic [PtrW-1:0] tag_wptr_q, tag_rptr_q;
  tag_t tag_mem_q [MaxTrans];
  tag_t tag_head;
  logic [DataWidth:0] rd_head;
  assign addr_inc = (addr_q & ~AddrWidth'(Bytes - 1)) + AddrWidth'(Bytes);
`ifdef MEM_BURST_SPLITTER_WRAP_EN
  localparam int unsigned OffW = $clog2(Bytes);
  logic [LenWidth-1:0] len_q, len_d;
  logic wrap_q, wrap_d;
  logic [LenWidth:0] beats;
  logic [AddrWidth-1:0] win_mask;
  assign beats = {1'b0, len_q} + (LenWidth + 1)'(1);
  assign win_mask = (AddrWidth'(beats) << OffW) - AddrWidth'(1);
  // Wrapping keeps the window base and advances only the offset inside the window
  assign addr_nxt = (wrap_q && is_pow2(32'(beats))) ? (addr_q & ~win_mask) | (addr_inc & win_mask) : addr_inc;
`else
  assign addr_nxt = addr_inc;
`endif
  // Every slot of the read buffer is reserved by an outstanding request, so it can never overflow
  assign credit_ok = ({1'b0, tag_cnt_q} + {1'b0, rd_cnt}) < (CntW + 1)'(MaxTrans);
  assign req_o = state_q == BURST && credit_ok && (!we_q || wvalid_i);
  assign grant = req_o && gnt_i;
  assign burst_ready_o = state_q == IDLE;
  assign addr_o = state_q == BURST ? addr_q : '0;
  assign we_o = state_q == BURST && we_q;
  assign wdata_o = we_o ? wdata_i : '0;
  assign strb_o = we_o ? wstrb_i : '0;
  assign wready_o = grant && we_q;
  always_comb begin
    state_d = state_q;
    addr_d = addr_q;
    cnt_d = cnt_q;
    we_d = we_q;
`ifdef MEM_BURST_SPLITTER_WRAP_EN
    len_d = len_q;
    wrap_d = wrap_q;
`endif
    if (state_q == IDLE && burst_valid_i) begin
      state_d = BURST;
      addr_d = burst_addr_i;
      cnt_d = burst_len_i;
      we_d = burst_we_i;
`ifdef MEM_BURST_SPLITTER_WRAP_EN
      len_d = burst_len_i;
      wrap_d = burst_wrap_i;
`endif
    end else if (grant) begin
      addr_d = addr_nxt;
      cnt_d = cnt_q - LenWidth'(1);
      state_d = cnt_q == '0 ? IDLE : BURST;
    end
  end
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      addr_q <= '0;
      cnt_q <= '0;
      we_q <= 1'b0;
`ifdef MEM_BURST_SPLITTER_WRAP_EN
      len_q <= '0;
      wrap_q <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      addr_q <= addr_d;
      cnt_q <= cnt_d;
      we_q <= we_d;
`ifdef MEM_BURST_SPLITTER_WRAP_EN
      len_q <= len_d;
      wrap_q <= wrap_d;
`endif
    end
  end
  // In-order tag queue: one entry per granted beat; responses with no entry are stray and ignored
  assign tag_head = tag_mem_q[tag_rptr_q];
  assign resp = mem_rvalid_i && tag_cnt_q != '0;
  assign rd_push = resp && !tag_head.we;
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tag_cnt_q <= '0;
      tag_wptr_q <= '0;
      tag_rptr_q <= '0;
    end else begin
      tag_cnt_q <= tag_cnt_q + CntW'(grant) - CntW'(resp);
      if (grant) tag_wptr_q <= tag_wptr_q == PtrW'(MaxTrans - 1) ? '0 : tag_wptr_q + PtrW'(1);
      if (resp) tag_rptr_q <= tag_rptr_q == PtrW'(MaxTrans - 1) ? '0 : tag_rptr_q + PtrW'(1);
    end
  end
  always_ff @(posedge clk_i) begin
    if (grant) tag_mem_q[tag_wptr_q] <= '{we: we_q, last: cnt_q == '0};
  end
  fifo_v3 #(
    .DATA_WIDTH(DataWidth + 1),
    .DEPTH     (MaxTrans)
  ) i_rd_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .empty_o(rd_empty),
    .usage_o(rd_cnt),
    .data_i ({tag_head.last, mem_rdata_i}),
    .push_i (rd_push),
    .data_o (rd_head),
    .pop_i  (rd_pop)
  );
  assign rvalid_o = !rd_empty;
  assign rd_pop = rvalid_o && rready_i;
  assign rdata_o = rvalid_o ? rd_head[DataWidth-1:0] : '0;
  assign rlast_o = rvalid_o && rd_head[DataWidth];
endmodule
